cmd_resp_wrapper: RTL and testbench
===================================

# cmd_resp_wrapper

DUT-side end of the remote command link. Receives 8N1 UART bytes on `RX`, assembles two bytes (high first) into a 16-bit command for the command processor, and serializes 8-bit acknowledge/response bytes back on `TX`. It sits between the board RX/TX pins and the command FSM inside `KnightsTour`, and is the counterpart of `RemoteComm`.

## Interface
- `BAUD_DIV`, 5208: clock cycles per UART bit.
- `BYTE_TO`, 1_048_576: cycles allowed between end of the high byte and end of the low byte before the partial command is dropped.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `RX`  in  1  serial in, asynchronous to `clk`, idle high.
- `TX`  out  1  serial out, idle high.
- `cmd`  out  16  last complete command, `{high_byte, low_byte}`.
- `cmd_rdy`  out  1  level; a new `cmd` is available.
- `clr_cmd_rdy`  in  1  consumer clears `cmd_rdy`.
- `resp`  in  8  response byte, sampled on `trmt`.
- `trmt`  in  1  single-cycle request to send `resp`.
- `tx_done`  out  1  level; the last response has fully left `TX`.
- `frm_err`  out  1  one-cycle pulse; a bad stop bit was detected.

## Operation
- **RX front end**
  - `RX` passes through a 2-flop synchronizer; both flops preset to 1 on reset.
  - A falling edge in idle starts the half-bit counter. At `BAUD_DIV/2` the start bit is re-checked; if it is high, the frame is aborted as a glitch.
  - Data bits are sampled at each bit midpoint, LSB first, then the stop bit is sampled.
  - Stop bit = 1: one-cycle internal `byte_rdy` with the 8-bit data.
  - Stop bit = 0: byte discarded, `frm_err` pulses.
- **Assembly FSM**
  - States: `WAIT_HI`, `WAIT_LO`.
  - `WAIT_HI` + `byte_rdy`: latch high byte, go to `WAIT_LO`, start the timeout counter.
  - `WAIT_LO` + `byte_rdy`: `cmd <= {hi, byte}`, set `cmd_rdy`, go to `WAIT_HI`.
  - `WAIT_LO` + timeout reaching `BYTE_TO`: drop the high byte, go to `WAIT_HI`.
  - Any `frm_err`: go to `WAIT_HI`.
- **`cmd_rdy`**
  - Set on completion of the low byte.
  - Cleared by `clr_cmd_rdy`, or when a start bit is validated in `WAIT_HI`.
  - If set and clear occur in the same cycle, set wins.
  - Overrun: a new command overwrites `cmd` and `cmd_rdy` stays 1.
- **TX**
  - `trmt` while idle loads the 10-bit frame `{1, resp, 0}` and shifts it out LSB first, one bit per `BAUD_DIV` cycles.
  - `tx_done` clears on an accepted `trmt` and sets after the stop bit's full period.
  - `trmt` while busy is ignored; the frame in flight is unaffected.
- RX and TX operate independently (full duplex).

## Timing
- Reset values: `TX`=1, `cmd`=16'h0000, `cmd_rdy`=0, `tx_done`=0, `frm_err`=0, FSM in `WAIT_HI`, both shifters idle.
- Asserting `rst` mid-frame abandons the frame immediately. The first valid start is recognized after `rst` deasserts and `RX` has been seen high.
- RX latency:
  - `cmd_rdy` rises 2 (synchronizer) + 1 cycles after the low byte's stop-bit midpoint.
  - That is about 9.5×`BAUD_DIV`+3 cycles after the low byte's start edge.
- TX latency:
  - `TX` drops to the start bit the cycle after `trmt`.
  - `tx_done` rises 10×`BAUD_DIV`+1 cycles after `trmt`.
- The `frm_err` pulse coincides with the stop-bit sample cycle (+0).
- `cmd` is stable from the cycle `cmd_rdy` rises until the next completed command.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` and `asm_state_t` enums
  - frame length constant `FRAME_BITS = 10`
  - default baud divisor constant
- Sub-module `uart_rx`: synchronizer, start validation, bit counter, shifter. Outputs `rx_data[7:0]`, `byte_rdy`, `frm_err`.
- The assembly FSM, timeout counter, and TX serializer stay in `cmd_resp_wrapper`.

## Test plan
Benches use `BAUD_DIV`=16 and `BYTE_TO`=400.
- **Command receive:** send bytes 8'h20, 8'h00 back-to-back → `cmd`=16'h2000, `cmd_rdy`=1 about 152 cycles after the second start edge. Then pulse `clr_cmd_rdy` → `cmd_rdy`=0 next cycle.
- **Response transmit:** `trmt` with `resp`=8'hA5 → `TX` reads 0,1,0,1,0,0,1,0,1,1 at the bit centers. `tx_done`=1 at cycle 161; a second `trmt` at cycle 50 is ignored.
- **Inter-byte timeout:** send 8'h34, idle 500 cycles, send 8'h56, 8'h78 → `cmd`=16'h5678, with no command formed from 8'h34.
- **Framing and glitch errors:**
  - Send 8'h12 with stop bit = 0 → `frm_err` one pulse, FSM in `WAIT_HI`.
  - A 4-cycle low glitch on `RX` → no byte and no `frm_err`.
- **Simultaneous events:** assert `clr_cmd_rdy` in the same cycle the low byte completes → `cmd_rdy`=1. A new command 16'hBEEF arriving while `cmd_rdy`=1 → `cmd`=16'hBEEF.
- **Reset mid-operation:** assert `rst` midway through the high byte and through a TX frame → `TX`=1 and `cmd_rdy`=0 immediately. A following 16'h2000 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the command link
package uart_pkg;

    localparam int FRAME_BITS       = 10;
    localparam int DEFAULT_BAUD_DIV = 5208;
    localparam int DEFAULT_BYTE_TO  = 1048576;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } asm_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with synchronizer and start-bit glitch rejection
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       byte_rdy,
    output logic       frm_err,
    output logic       start_ok
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_byte_rdy;
    logic            r_frm_err;
    logic            r_start_ok;
    logic            w_fall;

    // r_prev resets low so a start is only accepted after the line has been seen high
    assign w_fall = r_prev & ~r_sync2;

    // Two-flop synchronizer (preset high = idle line) plus one-cycle history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Frame FSM: validate start at half bit, sample data at bit centers, check stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_byte_rdy <= 1'b0;
            r_frm_err  <= 1'b0;
            r_start_ok <= 1'b0;
        end else begin
            r_byte_rdy <= 1'b0;
            r_frm_err  <= 1'b0;
            r_start_ok <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_state <= RX_IDLE;
                        end else begin
                            r_state    <= RX_DATA;
                            r_bit      <= '0;
                            r_start_ok <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            r_byte_rdy <= 1'b1;
                        end else begin
                            r_frm_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data  = r_shift;
    assign byte_rdy = r_byte_rdy;
    assign frm_err  = r_frm_err;
    assign start_ok = r_start_ok;

endmodule

// File: rtl/cmd_resp_wrapper.sv
// rtl/cmd_resp_wrapper.sv - UART command assembler and response serializer
module cmd_resp_wrapper
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int BYTE_TO  = DEFAULT_BYTE_TO
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done,
    output logic        frm_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(BYTE_TO);
    localparam int NW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(BYTE_TO - 1);
    localparam logic [NW-1:0] BN_LAST  = NW'(FRAME_BITS - 1);

    logic [7:0]            w_rx_data;
    logic                  w_byte_rdy;
    logic                  w_frm_err;
    logic                  w_start_ok;

    asm_state_t            r_asm;
    logic [7:0]            r_hi;
    logic [15:0]           r_cmd;
    logic                  r_cmd_rdy;
    logic [TW-1:0]         r_to;

    logic [FRAME_BITS-1:0] r_tx_shift;
    logic                  r_tx_busy;
    logic [CW-1:0]         r_baud;
    logic [NW-1:0]         r_bitn;
    logic                  r_tx_done;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .rx_data  (w_rx_data),
        .byte_rdy (w_byte_rdy),
        .frm_err  (w_frm_err),
        .start_ok (w_start_ok)
    );

    // Two-byte assembly with inter-byte timeout; a set of cmd_rdy overrides a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm     <= WAIT_HI;
            r_hi      <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_to      <= '0;
        end else begin
            if (clr_cmd_rdy || (w_start_ok && r_asm == WAIT_HI)) begin
                r_cmd_rdy <= 1'b0;
            end
            case (r_asm)
                WAIT_HI: begin
                    if (w_byte_rdy) begin
                        r_hi  <= w_rx_data;
                        r_to  <= '0;
                        r_asm <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (w_byte_rdy) begin
                        r_cmd     <= {r_hi, w_rx_data};
                        r_cmd_rdy <= 1'b1;
                        r_asm     <= WAIT_HI;
                    end else if (w_frm_err || r_to == TO_LAST) begin
                        r_asm <= WAIT_HI;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                default: r_asm <= WAIT_HI;
            endcase
        end
    end

    // Response serializer: the shifter backfills ones so TX naturally idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '1;
            r_tx_busy  <= 1'b0;
            r_baud     <= '0;
            r_bitn     <= '0;
            r_tx_done  <= 1'b0;
        end else if (!r_tx_busy) begin
            if (trmt) begin
                r_tx_shift <= {1'b1, resp, 1'b0};
                r_tx_busy  <= 1'b1;
                r_baud     <= '0;
                r_bitn     <= '0;
                r_tx_done  <= 1'b0;
            end
        end else if (r_baud == BIT_LAST) begin
            r_baud     <= '0;
            r_tx_shift <= {1'b1, r_tx_shift[FRAME_BITS-1:1]};
            if (r_bitn == BN_LAST) begin
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
            end else begin
                r_bitn <= r_bitn + 1'b1;
            end
        end else begin
            r_baud <= r_baud + 1'b1;
        end
    end

    assign TX      = r_tx_shift[0];
    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;
    assign tx_done = r_tx_done;
    assign frm_err = w_frm_err;

endmodule

// File: tb/tb_cmd_resp_wrapper.sv
// tb/tb_cmd_resp_wrapper.sv - scoreboard bench for cmd_resp_wrapper
module tb_cmd_resp_wrapper;

    localparam int BD  = 16;
    localparam int BTO = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        trmt = 1'b0;
    logic [7:0]  resp = 8'h00;
    wire         TX;
    wire         cmd_rdy;
    wire         tx_done;
    wire         frm_err;
    wire  [15:0] cmd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];
    int          frm_err_seen = 0;
    int          frm_err_exp = 0;
    bit          have_hi = 1'b0;
    logic [7:0]  hi_byte = 8'h00;
    int          hi_time = 0;
    int          tx_free = 0;
    int          rdy_rise_cyc = 0;
    bit          tx_rst_seen = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_ferr = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cmd_resp_wrapper #(
        .BAUD_DIV (BD),
        .BYTE_TO  (BTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .frm_err     (frm_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        RX = v;
        tick(BD);
    endtask

    // Reference model of the link: two good bytes within BYTE_TO form a command
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            have_hi = 1'b0;
            frm_err_exp++;
        end else if (have_hi && (cyc - hi_time) < BTO) begin
            exp_cmd_q.push_back({hi_byte, b});
            have_hi = 1'b0;
        end else begin
            have_hi = 1'b1;
            hi_byte = b;
            hi_time = cyc;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        model_byte(b, stop_ok);
        drive_bit(stop_ok);
        RX = 1'b1;
    endtask

    task automatic send_resp(input logic [7:0] b);
        if (cyc < tx_free) tick(tx_free - cyc + 1);
        resp = b;
        trmt = 1'b1;
        exp_tx_q.push_back(b);
        tick(1);
        trmt = 1'b0;
        tx_free = cyc + 170;
    endtask

    // Command monitor: every rising cmd_rdy must match the next expected command
    always @(negedge clk) begin
        if (cmd_rdy && !prev_rdy) begin
            rdy_rise_cyc = cyc;
            if (exp_cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got %0h expected none", cmd);
            end else begin
                check("cmd_value", cmd, exp_cmd_q.pop_front());
            end
        end
        if (frm_err) frm_err_seen++;
        if (frm_err && prev_ferr) begin
            checks++;
            errors++;
            $display("FAIL frm_err_width: got 2+ cycles expected 1");
        end
        prev_rdy  <= cmd_rdy;
        prev_ferr <= frm_err;
    end

    always @(posedge rst) tx_rst_seen = 1'b1;

    // TX monitor: decode each frame at bit centers and compare with the expected byte
    initial begin : tx_mon
        logic [7:0] b;
        logic       sbit;
        logic       pbit;
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) begin
                tx_rst_seen = 1'b0;
                repeat (7) @(negedge clk);
                sbit = TX;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                pbit = TX;
                if (!tx_rst_seen) begin
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", b);
                    end else begin
                        check("tx_start_bit", sbit, 1'b0);
                        check("tx_byte", b, exp_tx_q.pop_front());
                        check("tx_stop_bit", pbit, 1'b1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         t0;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        bit         ok;
        bit         long_gap;

        tick(3);
        check("rst_tx", TX, 1'b1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", cmd_rdy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_frm_err", frm_err, 1'b0);
        rst = 1'b0;
        tick(5);

        // command receive and clear
        send_byte(8'h20, 1'b1);
        t0 = cyc;
        send_byte(8'h00, 1'b1);
        tick(2);
        check("rx_cmd_rdy", cmd_rdy, 1'b1);
        check("rx_cmd", cmd, 16'h2000);
        check("rx_latency", ((rdy_rise_cyc - t0) >= 148 && (rdy_rise_cyc - t0) <= 162), 1'b1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("clr_cmd_rdy", cmd_rdy, 1'b0);

        // response transmit, busy trmt ignored, tx_done timing
        resp = 8'hA5;
        trmt = 1'b1;
        exp_tx_q.push_back(8'hA5);
        tick(1);
        trmt = 1'b0;
        check("tx_start_low", TX, 1'b0);
        check("tx_done_cleared", tx_done, 1'b0);
        tick(48);
        resp = 8'h5A;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        tick(110);
        check("tx_done_early", tx_done, 1'b0);
        tick(1);
        check("tx_done_161", tx_done, 1'b1);
        tx_free = cyc + 20;
        tick(30);

        // inter-byte timeout
        send_byte(8'h34, 1'b1);
        tick(500);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        tick(2);
        check("timeout_cmd", cmd, 16'h5678);

        // framing error returns the assembler to WAIT_HI
        send_byte(8'h11, 1'b1);
        send_byte(8'h12, 1'b0);
        tick(20);
        check("frm_err_count", frm_err_seen, frm_err_exp);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        tick(2);
        check("after_frm_cmd", cmd, 16'hABCD);

        // short glitch is rejected
        RX = 1'b0;
        tick(4);
        RX = 1'b1;
        tick(200);
        check("glitch_no_frm", frm_err_seen, frm_err_exp);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h4D, 1'b1);
        tick(2);
        check("glitch_cmd", cmd, 16'h3C4D);

        // clear coinciding with completion: set wins
        send_byte(8'h9E, 1'b1);
        fork
            send_byte(8'h01, 1'b1);
            begin
                tick(140);
                clr_cmd_rdy = 1'b1;
                for (int k = 0; k < 40 && !cmd_rdy; k++) @(negedge clk);
                clr_cmd_rdy = 1'b0;
            end
        join
        tick(2);
        check("set_wins", cmd_rdy, 1'b1);

        // overrun
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        tick(2);
        check("overrun_cmd", cmd, 16'hBEEF);
        check("overrun_rdy", cmd_rdy, 1'b1);

        // reset midway through a high byte and a TX frame
        resp = 8'h3C;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", TX, 1'b1);
        check("rst_mid_rdy", cmd_rdy, 1'b0);
        check("rst_mid_cmd", cmd, 16'h0000);
        tick(3);
        RX = 1'b1;
        have_hi = 1'b0;
        rst = 1'b0;
        tick(200);
        tx_free = cyc;
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(2);
        check("post_rst_cmd", cmd, 16'h2000);

        // randomized full-duplex traffic
        for (int n = 0; n < 8; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            long_gap = ($urandom_range(0, 3) == 0);
            fork
                begin
                    send_byte(a, ok);
                    if (long_gap) tick(600);
                    else tick($urandom_range(0, 30));
                    send_byte(b, 1'b1);
                end
                send_resp(c);
            join
            tick(450);
        end

        tick(200);
        check("cmd_queue_empty", exp_cmd_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        check("frm_err_total", frm_err_seen, frm_err_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
